// File: rtl/picomips_pkg.sv
// Shared types and field geometry for the multi-cycle picoMIPS core.
// The geometry functions take the core parameters and return derived widths.
package picomips_pkg;

    typedef enum logic {
        SUBLEQ = 1'b0,
        MULTI  = 1'b1
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam int SW_REG  = 0;
    localparam int LED_REG = 1;

    function automatic int field_width(input int pc_w, input int imm_w);
        return (pc_w > imm_w) ? pc_w : imm_w;
    endfunction

    function automatic int instr_width(input int reg_w, input int pc_w, input int imm_w);
        return 1 + 2 * reg_w + field_width(pc_w, imm_w);
    endfunction

    function automatic int op_bit(input int reg_w, input int pc_w, input int imm_w);
        return instr_width(reg_w, pc_w, imm_w) - 1;
    endfunction

    function automatic int r1_msb(input int reg_w, input int pc_w, input int imm_w);
        return instr_width(reg_w, pc_w, imm_w) - 2;
    endfunction

    function automatic int r2_msb(input int reg_w, input int pc_w, input int imm_w);
        return instr_width(reg_w, pc_w, imm_w) - 2 - reg_w;
    endfunction

endpackage

// File: rtl/picomips_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// Register 0 reads the switches and ignores writes; register 1 drives the LEDs.
module picomips_regfile
    import picomips_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     sw,
    input  logic [REG_ADDR_WIDTH-1:0] raddr_a,
    input  logic [REG_ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0]     rdata_a,
    output logic [DATA_WIDTH-1:0]     rdata_b,
    input  logic                      we,
    input  logic [REG_ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     led
);

    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;
    localparam logic [REG_ADDR_WIDTH-1:0] SW_ADDR  = REG_ADDR_WIDTH'(SW_REG);
    localparam logic [REG_ADDR_WIDTH-1:0] LED_ADDR = REG_ADDR_WIDTH'(LED_REG);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != SW_ADDR)) begin
            regs[waddr] <= wdata;
        end
    end

    // Reads see the pre-write value, so r1 == r2 uses the old contents.
    assign rdata_a = (raddr_a == SW_ADDR) ? sw : regs[raddr_a];
    assign rdata_b = (raddr_b == SW_ADDR) ? sw : regs[raddr_b];
    assign led     = regs[LED_ADDR];

endmodule

// File: rtl/picomips_seq.sv
// Multi-cycle picoMIPS core: FETCH/EXEC sequencer, pc, run/step control,
// branch-to-self halt detection and the SUBLEQ/MULTI datapath.
module picomips_seq
    import picomips_pkg::*;
#(
    parameter  int DATA_WIDTH     = 8,
    parameter  int REG_ADDR_WIDTH = 3,
    parameter  int PC_WIDTH       = 5,
    parameter  int IMM_WIDTH      = 8,
    localparam int FIELD_WIDTH    = field_width(PC_WIDTH, IMM_WIDTH),
    localparam int INSTR_WIDTH    = instr_width(REG_ADDR_WIDTH, PC_WIDTH, IMM_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   step,
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_addr,
    input  logic [DATA_WIDTH-1:0]  sw,
    output logic [DATA_WIDTH-1:0]  led,
    output logic                   halted,
    output logic                   busy
);

    localparam int OP_BIT     = op_bit(REG_ADDR_WIDTH, PC_WIDTH, IMM_WIDTH);
    localparam int R1_MSB     = r1_msb(REG_ADDR_WIDTH, PC_WIDTH, IMM_WIDTH);
    localparam int R2_MSB     = r2_msb(REG_ADDR_WIDTH, PC_WIDTH, IMM_WIDTH);
    localparam int PROD_WIDTH = DATA_WIDTH + IMM_WIDTH + 1;

    state_t                    state;
    logic [PC_WIDTH-1:0]       pc;
    logic                      step_q;

    opcode_t                   op;
    logic [REG_ADDR_WIDTH-1:0] r1;
    logic [REG_ADDR_WIDTH-1:0] r2;
    logic [FIELD_WIDTH-1:0]    field;
    logic [PC_WIDTH-1:0]       br_addr;
    logic [IMM_WIDTH-1:0]      imm;

    logic [DATA_WIDTH-1:0]     rdata_a;
    logic [DATA_WIDTH-1:0]     rdata_b;
    logic [DATA_WIDTH-1:0]     diff;
    logic signed [PROD_WIDTH-1:0] a_ext;
    logic signed [PROD_WIDTH-1:0] imm_ext;
    logic signed [PROD_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      we;
    logic                      taken;
    logic                      halt_hit;
    logic                      step_edge;
    logic [PC_WIDTH-1:0]       pc_next;
    logic                      unused_prod;

    assign op      = opcode_t'(instr[OP_BIT]);
    assign r1      = instr[R1_MSB -: REG_ADDR_WIDTH];
    assign r2      = instr[R2_MSB -: REG_ADDR_WIDTH];
    assign field   = instr[FIELD_WIDTH-1:0];
    assign br_addr = field[PC_WIDTH-1:0];
    assign imm     = field[IMM_WIDTH-1:0];

    picomips_regfile #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .sw      (sw),
        .raddr_a (r1),
        .raddr_b (r2),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .we      (we),
        .waddr   (r2),
        .wdata   (wdata),
        .led     (led)
    );

    // SUBLEQ: modular subtract, branch when the signed result is <= 0.
    assign diff  = rdata_b - rdata_a;
    assign taken = (op == SUBLEQ) && (diff[DATA_WIDTH-1] || (diff == '0));

    // MULTI: signed register times unsigned fraction; keeping bits above
    // IMM_WIDTH is the arithmetic shift followed by truncation.
    assign a_ext   = {{(IMM_WIDTH + 1){rdata_a[DATA_WIDTH-1]}}, rdata_a};
    assign imm_ext = {{(DATA_WIDTH + 1){1'b0}}, imm};
    assign prod    = a_ext * imm_ext;
    assign unused_prod = ^{prod[PROD_WIDTH-1], prod[IMM_WIDTH-1:0]};

    assign wdata    = (op == MULTI) ? prod[IMM_WIDTH+DATA_WIDTH-1:IMM_WIDTH] : diff;
    assign we       = (state == EXEC);
    assign halt_hit = taken && (br_addr == pc);
    assign pc_next  = taken ? br_addr : pc + PC_WIDTH'(1);

    // step_q runs every cycle, so an edge arriving outside IDLE is consumed
    // there and cannot launch a late instruction afterwards.
    assign step_edge = step && !step_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            pc     <= '0;
            step_q <= 1'b0;
            halted <= 1'b0;
            busy   <= 1'b0;
        end else begin
            step_q <= step;
            case (state)
                IDLE: begin
                    if (run || step_edge) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= EXEC;
                end
                EXEC: begin
                    if (halt_hit) begin
                        state  <= HALT;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        pc <= pc_next;
                        if (run) begin
                            state <= FETCH;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign instr_addr = pc;

endmodule

// File: tb/tb_picomips_seq.sv
// Directed bench for picomips_seq at default parameters, with a
// one-cycle-latency program ROM model.
module tb_picomips_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic [14:0] instr;
    logic [4:0]  instr_addr;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic        halted;
    logic        busy;

    logic [14:0] prog [32];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    picomips_seq dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .instr      (instr),
        .instr_addr (instr_addr),
        .sw         (sw),
        .led        (led),
        .halted     (halted),
        .busy       (busy)
    );

    always @(posedge clk) instr <= prog[instr_addr];

    function automatic logic [14:0] enc(input logic op, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [7:0] f);
        return {op, ra, rb, f};
    endfunction

    // Default filler: MULTI r0,r3,0 writes 0 to r3 and never branches.
    task automatic fill_default();
        for (int i = 0; i < 32; i++) prog[i] = enc(1'b1, 3'd0, 3'd3, 8'h00);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        run   = 1'b0;
        step  = 1'b0;
        fill_default();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b0; step = 1'b0; sw = 8'h00;
        fill_default();
        repeat (2) @(negedge clk);
        checks++;
        if (instr_addr !== 5'd0) begin failures++; $display("FAIL reset_pc: got %0d expected 0", instr_addr); end
        checks++;
        if (led !== 8'h00) begin failures++; $display("FAIL reset_led: got %h expected 00", led); end
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0) begin
            failures++; $display("FAIL reset_flags: got busy=%b halted=%b expected 0 0", busy, halted);
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (instr_addr !== 5'd0 || led !== 8'h00 || busy !== 1'b0 || halted !== 1'b0) begin
                failures++;
                $display("FAIL idle_cycle%0d: got pc=%0d led=%h busy=%b halted=%b expected 0 00 0 0",
                         i, instr_addr, led, busy, halted);
            end
        end
    endtask

    task automatic test_subleq_taken();
        apply_reset();
        prog[0] = enc(1'b0, 3'd0, 3'd2, 8'd7);   // r2 = 0 - 3 = FD, taken to 7
        prog[7] = enc(1'b0, 3'd2, 3'd1, 8'd0);   // r1 = 0 - FD = 03, not taken
        sw  = 8'h03;
        run = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_addr !== 5'd0 || busy !== 1'b1) begin
            failures++; $display("FAIL subleq_fetch: got pc=%0d busy=%b expected 0 1", instr_addr, busy);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (instr_addr !== 5'd7) begin failures++; $display("FAIL subleq_branch: got %0d expected 7", instr_addr); end
        checks++;
        if (halted !== 1'b0) begin failures++; $display("FAIL subleq_nohalt: got %b expected 0", halted); end
        @(negedge clk);
        checks++;
        if (led !== 8'h00) begin failures++; $display("FAIL subleq_led_early: got %h expected 00", led); end
        @(negedge clk);
        checks++;
        if (led !== 8'h03) begin failures++; $display("FAIL subleq_r2_value: got led=%h expected 03", led); end
        checks++;
        if (instr_addr !== 5'd8) begin failures++; $display("FAIL subleq_not_taken: got %0d expected 8", instr_addr); end
        run = 1'b0;
    endtask

    task automatic test_multi();
        apply_reset();
        prog[0] = enc(1'b1, 3'd0, 3'd1, 8'h80);
        prog[1] = enc(1'b1, 3'd0, 3'd1, 8'h80);
        prog[2] = enc(1'b1, 3'd0, 3'd1, 8'h40);
        sw  = 8'h40;
        run = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (led !== 8'h20) begin failures++; $display("FAIL multi_pos: got %h expected 20", led); end
        checks++;
        if (instr_addr !== 5'd1) begin failures++; $display("FAIL multi_pc1: got %0d expected 1", instr_addr); end
        sw = 8'hC0;
        repeat (2) @(negedge clk);
        checks++;
        if (led !== 8'hE0) begin failures++; $display("FAIL multi_neg: got %h expected E0", led); end
        run = 1'b0;                               // dropped during FETCH of pc 2
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL multi_exec_busy: got %b expected 1", busy); end
        @(negedge clk);
        checks++;
        if (led !== 8'hF0) begin failures++; $display("FAIL multi_neg_quarter: got %h expected F0", led); end
        checks++;
        if (instr_addr !== 5'd3 || busy !== 1'b0) begin
            failures++; $display("FAIL multi_stop: got pc=%0d busy=%b expected 3 0", instr_addr, busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (instr_addr !== 5'd3) begin failures++; $display("FAIL multi_idle_hold: got %0d expected 3", instr_addr); end
    endtask

    task automatic test_halt();
        apply_reset();
        prog[4] = enc(1'b0, 3'd2, 3'd2, 8'd4);
        sw  = 8'h00;
        run = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (halted !== 1'b0 || instr_addr !== 5'd4) begin
            failures++; $display("FAIL halt_before: got halted=%b pc=%0d expected 0 4", halted, instr_addr);
        end
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL halt_set: got halted=%b busy=%b expected 1 0", halted, busy);
        end
        step = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            step = ~step;
            checks++;
            if (instr_addr !== 5'd4 || halted !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL halt_hold%0d: got pc=%0d halted=%b busy=%b expected 4 1 0",
                         i, instr_addr, halted, busy);
            end
        end
        run = 1'b0; step = 1'b0;
    endtask

    task automatic test_single_step();
        apply_reset();
        prog[0] = enc(1'b1, 3'd0, 3'd1, 8'h80);
        sw   = 8'h10;
        step = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL step_start: got busy=%b expected 1", busy); end
        repeat (11) @(negedge clk);
        checks++;
        if (instr_addr !== 5'd1 || busy !== 1'b0) begin
            failures++; $display("FAIL step_once: got pc=%0d busy=%b expected 1 0", instr_addr, busy);
        end
        checks++;
        if (led !== 8'h08) begin failures++; $display("FAIL step_led: got %h expected 08", led); end
        step = 1'b0;
        repeat (2) @(negedge clk);
        step = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (instr_addr !== 5'd2 || busy !== 1'b0) begin
            failures++; $display("FAIL step_twice: got pc=%0d busy=%b expected 2 0", instr_addr, busy);
        end
        step = 1'b0;
    endtask

    task automatic test_wrap();
        apply_reset();
        prog[0]  = enc(1'b0, 3'd0, 3'd2, 8'd31);  // 0 - 0 = 0 is taken
        sw  = 8'h00;
        run = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (instr_addr !== 5'd31) begin failures++; $display("FAIL wrap_zero_taken: got %0d expected 31", instr_addr); end
        repeat (2) @(negedge clk);
        checks++;
        if (instr_addr !== 5'd0 || halted !== 1'b0) begin
            failures++; $display("FAIL wrap_pc: got pc=%0d halted=%b expected 0 0", instr_addr, halted);
        end
        run = 1'b0;
    endtask

    task automatic test_abort();
        apply_reset();
        prog[0] = enc(1'b1, 3'd0, 3'd1, 8'h80);
        prog[1] = enc(1'b1, 3'd0, 3'd1, 8'hFF);   // would write 3F
        sw  = 8'h40;
        run = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (led !== 8'h20 || instr_addr !== 5'd1) begin
            failures++; $display("FAIL abort_setup: got led=%h pc=%0d expected 20 1", led, instr_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (led !== 8'h00 || instr_addr !== 5'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_now: got led=%h pc=%0d busy=%b expected 00 0 0", led, instr_addr, busy);
        end
        @(negedge clk);
        checks++;
        if (led !== 8'h00 || instr_addr !== 5'd0) begin
            failures++; $display("FAIL abort_hold: got led=%h pc=%0d expected 00 0", led, instr_addr);
        end
        run   = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_subleq_taken();
        test_multi();
        test_halt();
        test_single_step();
        test_wrap();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/picomips_seq.md
# picomips_seq

Parametrised multi-cycle picoMIPS core. It replaces the fixed-width core's free-running cycle generator and program counter with an explicit fetch/execute state machine, and adds an internal register file with switch and LED mapping. It also adds run/single-step control and halt detection. The core sits between the synchronous program memory and the board I/O, executing the SUBLEQ and MULTI instruction set at any data width or register count.

## Interface
- `DATA_WIDTH`, 8: register and ALU width.
- `REG_ADDR_WIDTH`, 3: register address bits; register count is 2^REG_ADDR_WIDTH.
- `PC_WIDTH`, 5: program address bits.
- `IMM_WIDTH`, 8: MULTI immediate width, an unsigned fraction scaled by 2^-IMM_WIDTH.
- `FIELD_WIDTH` (derived) = max(PC_WIDTH, IMM_WIDTH).
- `INSTR_WIDTH` (derived) = 1 + 2·REG_ADDR_WIDTH + FIELD_WIDTH; 15 at the default parameter values.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; while high, the core executes continuously.
- step  in  1  a rising edge executes exactly one instruction while run is low.
- instr  in  INSTR_WIDTH  program memory data, valid one cycle after instr_addr.
- instr_addr  out  PC_WIDTH  registered program counter.
- sw  in  DATA_WIDTH  switch input, read as register 0.
- led  out  DATA_WIDTH  register 1 contents, registered.
- halted  out  1  high once the core has detected a branch-to-self.
- busy  out  1  high in FETCH and EXEC.

## Operation
- Instruction field layout, MSB first: op[1], r1[REG_ADDR_WIDTH], r2[REG_ADDR_WIDTH], field[FIELD_WIDTH].
  - branch address = field[PC_WIDTH-1:0]
  - imm = field[IMM_WIDTH-1:0]
- op=0, SUBLEQ:
  - r2 ← r2 − r1, modulo 2^DATA_WIDTH.
  - Branch is taken when the result, interpreted as signed, is ≤ 0.
- op=1, MULTI:
  - r2 ← (signed r1 × unsigned imm) >>> IMM_WIDTH.
  - The product is full width; the shift is arithmetic; the result is truncated to DATA_WIDTH.
  - MULTI never branches.
- Register 0 always reads `sw`; writes to register 0 are discarded.
- Register 1 drives `led` directly. All other registers are ordinary storage.
- r1 = r2 is legal; the read value is the pre-write value.
- States:
  - IDLE: from here, run=1 goes to FETCH; otherwise a step rising edge goes to FETCH.
  - FETCH: always goes to EXEC.
  - EXEC: goes to FETCH if run=1, otherwise IDLE. If halt is detected, it goes to HALT instead.
  - HALT: absorbing; only reset leaves it.
- Next PC = branch address if the branch is taken, else pc+1, wrapping from 2^PC_WIDTH−1 to 0.
- Halt detection: a taken SUBLEQ whose branch address equals the current pc.
  - The register write still occurs.
  - pc is left unchanged.
  - halted is set.
- Step edge detection uses an internal registered copy of step. run has priority over step. A step edge seen outside IDLE is ignored.

## Timing
- Reset (asynchronous, active-low) sets:
  - state = IDLE
  - pc = 0, so instr_addr = 0
  - all registers = 0, so led = 0
  - halted = 0, busy = 0
  - the step edge register = 0
- Each instruction takes 2 cycles.
  - FETCH: instr_addr = pc, and memory samples it.
  - EXEC: instr is valid. Decode, read, compute, register write and PC update all complete at the EXEC→next edge.
- led updates at the end of the EXEC cycle that writes register 1.
- halted asserts at the end of the halting EXEC cycle.
- Reset asserted in any state, including mid-EXEC, aborts the pending write and pc update immediately.
- Continuous run gives 1 instruction per 2 cycles. Dropping run during FETCH still completes that instruction.

## Structure
- Package `picomips_pkg` holds:
  - the `opcode_t` enum (SUBLEQ=0, MULTI=1)
  - the `state_t` enum (IDLE, FETCH, EXEC, HALT)
  - field index functions derived from the parameters
  - register indices SW_REG=0, LED_REG=1
- Sub-module `picomips_regfile`:
  - two combinational read ports and one synchronous write port
  - asynchronous active-low clear
  - sw and led mapping handled inside it
- The top level `picomips_seq` holds the FSM, pc, step edge detector and ALU.

## Test plan
- Reset and idle: release reset with run=0 and step=0 for 10 cycles → instr_addr=0, led=0, busy=0, halted=0 throughout.
- SUBLEQ taken: sw=0x03, run=1, pc0 = SUBLEQ r0,r2,→7 with r2=0 → r2=0xFD; pc becomes 7 after 2 cycles.
- MULTI: sw=0x40, pc0 = MULTI r0,r1,imm=0x80 → led=0x20. With sw=0xC0 (−64) → led=0xE0.
- Halt: pc4 = SUBLEQ r2,r2,→4 → halted=1 and busy=0; instr_addr stays 4 for 20 cycles despite run=1.
- Single step: run=0, step held high for 12 cycles → exactly one instruction executes and pc advances by 1; a second rising edge advances pc by 1 again.
- Wrap and abort:
  - PC wrap: a non-branching instruction at pc=31 → next instr_addr=0.
  - Abort: reset asserted during the EXEC of a write to r1 → led=0 and pc=0 immediately.
